// File: rtl/l2_rr_arbiter.sv
// rtl/l2_rr_arbiter.sv - round-robin arbiter sharing one L2 port between icache and dcache
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (adds timeout_err port).
module l2_rr_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  L2_read,
    output logic                  L2_write,
    output logic [ADDR_WIDTH-1:0] L2_addr,
    output logic [LINE_WIDTH-1:0] L2_wdata,
    input  logic [LINE_WIDTH-1:0] L2_rdata,
    input  logic                  L2_resp
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic INST     = 1'b0;
    localparam logic DATA     = 1'b1;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state;
    state_t                state_next;
    // The current owner doubles as the round-robin pointer: both update on every grant.
    logic                  last;
    logic                  op;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic i_active;
    logic d_active;
    logic grant_valid;
    logic grant_data;
    logic grant_write;
    logic timed_out;
    logic done;

    assign i_active    = i_mem_read | i_mem_write;
    assign d_active    = d_mem_read | d_mem_write;
    assign grant_valid = (state == IDLE) && (i_active || d_active);
    assign grant_data  = d_active && (!i_active || (last == INST));
    assign grant_write = grant_data ? d_mem_write : i_mem_write;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wd_cnt;

    assign timed_out = (state == BUSY) && !L2_resp && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_valid) begin
                wd_cnt <= '0;
            end else if ((state == BUSY) && !L2_resp) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign done = (state == BUSY) && (L2_resp || timed_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_active || d_active) state_next = BUSY;
            BUSY:    if (done) state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction context is frozen at grant; requester inputs are ignored afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= INST;
            op      <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_valid) begin
            last   <= grant_data;
            op     <= grant_write ? OP_WRITE : OP_READ;
            addr_q <= grant_data ? d_addr : i_addr;
            if (grant_write) begin
                wdata_q <= grant_data ? d_wdata : i_wdata;
            end
        end
    end

    always_comb begin
        L2_read  = 1'b0;
        L2_write = 1'b0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (state == BUSY) begin
            L2_read  = (op == OP_READ);
            L2_write = (op == OP_WRITE);
            if (done) begin
                if (last == DATA) d_resp = 1'b1;
                else              i_resp = 1'b1;
            end
            // A watchdog completion has L2_resp low, so the owner sees a zero line.
            if (L2_resp) begin
                if (last == DATA) d_rdata = L2_rdata;
                else              i_rdata = L2_rdata;
            end
        end
    end

    assign L2_addr  = addr_q;
    assign L2_wdata = wdata_q;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// tb/tb_l2_rr_arbiter.sv - self-checking bench for l2_rr_arbiter
module tb_l2_rr_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic          d_mem_read = 1'b0, d_mem_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [LW-1:0] i_wdata = '0, d_wdata = '0, L2_rdata = '0;
    logic          L2_resp = 1'b0;
    logic [LW-1:0] i_rdata, d_rdata, L2_wdata;
    logic [AW-1:0] L2_addr;
    logic          i_resp, d_resp, L2_read, L2_write;
`ifdef ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int            l2_lat   = 1;
    bit            l2_en    = 1'b1;
    logic [LW-1:0] l2_pat   = '0;
    int            busy_cnt = 0;

    l2_rr_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write),
        .i_addr(i_addr),
        .i_wdata(i_wdata),
        .i_rdata(i_rdata),
        .i_resp(i_resp),
        .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_resp(d_resp),
        .L2_read(L2_read),
        .L2_write(L2_write),
        .L2_addr(L2_addr),
        .L2_wdata(L2_wdata),
        .L2_rdata(L2_rdata),
        .L2_resp(L2_resp)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level reference: phase 0 free, 1 serving, 2 one-cycle cooldown.
    int            m_phase  = 0;
    bit            m_own_d  = 1'b0;
    bit            m_wr     = 1'b0;
    bit            m_pref_d = 1'b1;
    bit            m_terr   = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [LW-1:0] m_wdata  = '0;
    int            m_wait   = 0;
    int            grant_log[$];

    wire i_req  = i_mem_read | i_mem_write;
    wire d_req  = d_mem_read | d_mem_write;
    wire pick_d = d_req && (!i_req || m_pref_d);
    wire pick_w = pick_d ? d_mem_write : i_mem_write;
`ifdef ARB_TIMEOUT_EN
    wire m_to = (m_phase == 1) && !L2_resp && (m_wait == TO - 1);
`else
    wire m_to = 1'b0;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  <= 0;
            m_own_d  <= 1'b0;
            m_wr     <= 1'b0;
            m_pref_d <= 1'b1;
            m_terr   <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wait   <= 0;
            grant_log.delete();
        end else begin
            case (m_phase)
                0: if (i_req || d_req) begin
                    m_phase  <= 1;
                    m_own_d  <= pick_d;
                    m_pref_d <= !pick_d;
                    m_wr     <= pick_w;
                    m_addr   <= pick_d ? d_addr : i_addr;
                    if (pick_w) m_wdata <= pick_d ? d_wdata : i_wdata;
                    m_wait   <= 0;
                    grant_log.push_back(pick_d ? 1 : 0);
                end
                1: if (L2_resp || m_to) begin
                    m_phase <= 2;
                    if (m_to) m_terr <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    wire           e_busy   = (m_phase == 1);
    wire           e_done   = e_busy && (L2_resp || m_to);
    wire [LW-1:0]  e_i_rdata = (e_busy && L2_resp && !m_own_d) ? L2_rdata : '0;
    wire [LW-1:0]  e_d_rdata = (e_busy && L2_resp && m_own_d) ? L2_rdata : '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("cmp_L2_read", L2_read, e_busy && !m_wr);
            check_bit("cmp_L2_write", L2_write, e_busy && m_wr);
            check_vec("cmp_L2_addr", LW'(L2_addr), LW'(m_addr));
            check_vec("cmp_L2_wdata", L2_wdata, m_wdata);
            check_bit("cmp_i_resp", i_resp, e_done && !m_own_d);
            check_bit("cmp_d_resp", d_resp, e_done && m_own_d);
            check_vec("cmp_i_rdata", i_rdata, e_i_rdata);
            check_vec("cmp_d_rdata", d_rdata, e_d_rdata);
            check_bit("resp_exclusive", i_resp & d_resp, 1'b0);
`ifdef ARB_TIMEOUT_EN
            check_bit("cmp_timeout_err", timeout_err, m_terr);
`endif
        end
    end

    // L2 stand-in: answers in the l2_lat-th cycle a command is held.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (L2_read || L2_write) busy_cnt++;
            else                     busy_cnt = 0;
            L2_resp  = l2_en && (busy_cnt == l2_lat);
            L2_rdata = L2_resp ? l2_pat : {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_reqs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i_resp || d_resp) && n < 40);
        check_bit("wait_resp_bounded", i_resp || d_resp, 1'b1);
    endtask

    int n;
    int who[3];
    int rcnt;
    int ccnt;

    initial begin
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_bit("rst_L2_read", L2_read, 1'b0);
        check_bit("rst_L2_write", L2_write, 1'b0);
        check_bit("rst_i_resp", i_resp, 1'b0);
        check_bit("rst_d_resp", d_resp, 1'b0);
        check_vec("rst_L2_addr", LW'(L2_addr), '0);
        check_vec("rst_L2_wdata", L2_wdata, '0);
        check_vec("rst_i_rdata", i_rdata, '0);
        check_vec("rst_d_rdata", d_rdata, '0);
`ifdef ARB_TIMEOUT_EN
        check_bit("rst_timeout_err", timeout_err, 1'b0);
`endif
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // dcache read, L2 answers in the 5th busy cycle
        l2_lat     = 5;
        l2_pat     = {16{8'hA5}};
        d_addr     = 16'h1230;
        d_mem_read = 1'b1;
        @(negedge clk);
        check_bit("t1_idle_no_cmd", L2_read, 1'b0);
        @(negedge clk);
        check_bit("t1_cmd_cycle1", L2_read, 1'b1);
        check_vec("t1_addr", LW'(L2_addr), LW'(16'h1230));
        wait_resp(n);
        check_int("t1_resp_wait", n, 4);
        check_bit("t1_d_resp", d_resp, 1'b1);
        check_bit("t1_i_resp", i_resp, 1'b0);
        check_vec("t1_d_rdata", d_rdata, {16{8'hA5}});
        tick();
        d_mem_read = 1'b0;
        @(negedge clk);
        check_bit("t1_recover_resp", d_resp, 1'b0);
        check_bit("t1_recover_cmd", L2_read, 1'b0);
        tick();

        // simultaneous requests held from reset
        do_reset();
        l2_lat     = 2;
        l2_pat     = {4{32'h1357_9BDF}};
        i_addr     = 16'h1111;
        d_addr     = 16'h2222;
        i_mem_read = 1'b1;
        d_mem_read = 1'b1;
        wait_resp(n);
        check_int("t2_first_wait", n, 3);
        check_bit("t2_first_is_data", d_resp, 1'b1);
        @(negedge clk);
        check_vec("t2_recover_addr", LW'(L2_addr), LW'(16'h2222));
        check_bit("t2_recover_cmd", L2_read, 1'b0);
        @(negedge clk);
        check_vec("t2_idle_addr", LW'(L2_addr), LW'(16'h2222));
        check_bit("t2_idle_cmd", L2_read, 1'b0);
        @(negedge clk);
        check_vec("t2_second_addr", LW'(L2_addr), LW'(16'h1111));
        check_bit("t2_second_cmd", L2_read, 1'b1);
        wait_resp(n);
        check_bit("t2_second_is_inst", i_resp, 1'b1);
        tick();
        clear_reqs();
        tick();

        // three consecutive ties
        do_reset();
        l2_lat = 1;
        for (int k = 0; k < 3; k++) begin
            i_addr     = 16'h3000 + 16'(k);
            d_addr     = 16'h4000 + 16'(k);
            i_mem_read = 1'b1;
            d_mem_read = 1'b1;
            wait_resp(n);
            who[k] = d_resp ? 1 : 0;
            tick();
            clear_reqs();
            tick();
        end
        check_int("t3_tie1_data", who[0], 1);
        check_int("t3_tie2_inst", who[1], 0);
        check_int("t3_tie3_data", who[2], 1);
        check_int("t3_model_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check_int("t3_model_g0", grant_log[0], 1);
            check_int("t3_model_g1", grant_log[1], 0);
            check_int("t3_model_g2", grant_log[2], 1);
        end

        // write line captured at grant, requester drops and changes data mid-transaction
        do_reset();
        l2_lat      = 4;
        l2_pat      = {4{32'h0BAD_F00D}};
        d_wdata     = {8{16'hDEAD}};
        d_addr      = 16'h0ABC;
        d_mem_write = 1'b1;
        tick();
        d_wdata     = '0;
        d_mem_write = 1'b0;
        wait_resp(n);
        check_int("t4_resp_wait", n, 4);
        check_vec("t4_wdata_held", L2_wdata, {8{16'hDEAD}});
        check_bit("t4_write_cmd", L2_write, 1'b1);
        check_bit("t4_no_read", L2_read, 1'b0);
        check_bit("t4_d_resp", d_resp, 1'b1);
        tick();
        tick();

        // read and write together: write wins
        l2_lat      = 1;
        i_wdata     = {4{32'h0123_4567}};
        i_addr      = 16'h00F0;
        i_mem_read  = 1'b1;
        i_mem_write = 1'b1;
        wait_resp(n);
        check_int("t5_resp_wait", n, 2);
        check_bit("t5_write_cmd", L2_write, 1'b1);
        check_bit("t5_no_read", L2_read, 1'b0);
        check_bit("t5_i_resp", i_resp, 1'b1);
        check_vec("t5_wdata", L2_wdata, {4{32'h0123_4567}});
        tick();
        clear_reqs();
        tick();

        // reset in the second busy cycle
        l2_lat     = 10;
        d_addr     = 16'h5555;
        d_mem_read = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_bit("t6_async_drop", L2_read, 1'b0);
        d_mem_read = 1'b0;
        tick();
        reset = 1'b0;
        rcnt  = 0;
        ccnt  = 0;
        repeat (6) begin
            @(negedge clk);
            if (i_resp || d_resp) rcnt++;
            if (L2_read || L2_write) ccnt++;
        end
        check_int("t6_no_resp", rcnt, 0);
        check_int("t6_no_cmd", ccnt, 0);
        tick();

`ifdef ARB_TIMEOUT_EN
        // L2 never answers: watchdog fires in the 8th busy cycle
        do_reset();
        l2_en      = 1'b0;
        d_addr     = 16'h0777;
        d_mem_read = 1'b1;
        wait_resp(n);
        check_int("t7_timeout_wait", n, 9);
        check_bit("t7_d_resp", d_resp, 1'b1);
        check_vec("t7_d_rdata", d_rdata, '0);
        tick();
        d_mem_read = 1'b0;
        @(negedge clk);
        check_bit("t7_err_set", timeout_err, 1'b1);
        repeat (4) @(negedge clk);
        check_bit("t7_err_sticky", timeout_err, 1'b1);
        tick();
        do_reset();
        @(negedge clk);
        check_bit("t7_err_cleared", timeout_err, 1'b0);
        l2_en = 1'b1;
        tick();
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
